thread_context_bank: RTL and testbench

//  Parametrised multi-slot thread-context store for near-memory threading; successor of the single 32-bit save register.

---
 rtl/nmt_ctx_pkg.sv | 27 ++
 rtl/ctx_storage_ram.sv | 37 +++
 rtl/thread_context_bank.sv | 155 +++++++++++++++
 tb/tb_thread_context_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmt_ctx_pkg.sv
// Shared types and width helpers for the near-memory thread context bank.
package nmt_ctx_pkg;

  typedef enum logic {
    CTX_SAVE    = 1'b0,
    CTX_RESTORE = 1'b1
  } ctx_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE     = 3'd1,
    RD_PRIME = 3'd2,
    RESTORE  = 3'd3,
    ERR      = 3'd4
  } ctx_state_e;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int ctx_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CTX   = 4;
  localparam int DEF_NUM_WORDS = 8;
  localparam int DEF_SLOT_W    = ctx_idx_w(DEF_NUM_CTX);
  localparam int DEF_WORD_W    = ctx_idx_w(DEF_NUM_WORDS);

endpackage

// File: rtl/ctx_storage_ram.sv
// Context storage: one write port, one synchronous read port, no reset.
module ctx_storage_ram
  import nmt_ctx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register only updates on request, so it holds during consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/thread_context_bank.sv
// Multi-slot thread-context store: streams whole contexts in (save) and out (restore)
// over valid/ready, tracking which slots hold a complete context.
module thread_context_bank
  import nmt_ctx_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int NUM_WORDS        = 8,
  parameter int NUM_CTX          = 4,
  parameter int CLEAR_ON_RESTORE = 0,
  localparam int SLOT_W          = ctx_idx_w(NUM_CTX),
  localparam int WORD_W          = ctx_idx_w(NUM_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [SLOT_W-1:0]  cmd_slot,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_CTX-1:0] slot_valid,
  output logic               err,
  output logic               busy
);

  localparam int ADDR_W = SLOT_W + WORD_W;
  localparam int DEPTH  = NUM_CTX << WORD_W;
  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(NUM_WORDS - 1);
  localparam logic [SLOT_W:0]   SLOT_LIM = (SLOT_W + 1)'(NUM_CTX);

  ctx_state_e          r_state;
  ctx_state_e          w_state_nxt;
  logic [SLOT_W-1:0]   r_slot;
  logic [WORD_W-1:0]   r_idx;
  logic [NUM_CTX-1:0]  r_slot_valid;
  logic                r_out_valid;

  logic                w_cmd_fire;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_last;
  logic                w_slot_ok;
  logic                w_slot_hit;
  logic                w_is_save;
  logic [WORD_W-1:0]   w_idx_inc;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_cmd_fire = cmd_valid && (r_state == IDLE);
  assign w_in_fire  = in_valid && (r_state == SAVE);
  assign w_out_fire = r_out_valid && out_ready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_slot_ok  = ({1'b0, cmd_slot} < SLOT_LIM);
  assign w_slot_hit = w_slot_ok && r_slot_valid[cmd_slot];
  assign w_is_save  = (ctx_op_e'(cmd_op) == CTX_SAVE);
  assign w_idx_inc  = r_idx + 1'b1;

  // Word 0 is primed in RD_PRIME; afterwards each handshake prefetches the next word.
  assign w_rd_en   = (r_state == RD_PRIME) || (w_out_fire && !w_last);
  assign w_rd_addr = (r_state == RD_PRIME) ? {r_slot, {WORD_W{1'b0}}} : {r_slot, w_idx_inc};

  ctx_storage_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_in_fire),
    .i_wr_addr ({r_slot, r_idx}),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_cmd_fire)      w_state_nxt = IDLE;
        else if (!w_slot_ok)  w_state_nxt = ERR;
        else if (w_is_save)   w_state_nxt = SAVE;
        else if (w_slot_hit)  w_state_nxt = RD_PRIME;
        else                  w_state_nxt = ERR;
      end
      SAVE: begin
        if (w_in_fire && w_last) w_state_nxt = IDLE;
        else                     w_state_nxt = SAVE;
      end
      RD_PRIME: w_state_nxt = RESTORE;
      RESTORE: begin
        if (w_out_fire && w_last) w_state_nxt = IDLE;
        else                      w_state_nxt = RESTORE;
      end
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Slot/word bookkeeping, slot-valid tracking and restore valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_idx        <= '0;
      r_slot_valid <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_slot <= cmd_slot;
        r_idx  <= '0;
        if (w_slot_ok && w_is_save) r_slot_valid[cmd_slot] <= 1'b0;
      end
      if (w_in_fire) begin
        if (w_last) begin
          r_idx                <= '0;
          r_slot_valid[r_slot] <= 1'b1;
        end else begin
          r_idx <= w_idx_inc;
        end
      end
      if (r_state == RD_PRIME) r_out_valid <= 1'b1;
      if (w_out_fire) begin
        if (w_last) begin
          r_out_valid <= 1'b0;
          r_idx       <= '0;
          if (CLEAR_ON_RESTORE != 0) r_slot_valid[r_slot] <= 1'b0;
        end else begin
          r_idx <= w_idx_inc;
        end
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign in_ready   = (r_state == SAVE);
  assign busy       = (r_state != IDLE);
  assign err        = (r_state == ERR);
  assign out_valid  = r_out_valid;
  // The RAM read register is not reset; gating keeps out_data at zero when nothing is offered.
  assign out_data   = w_rd_data & {DATA_W{r_out_valid}};
  assign slot_valid = r_slot_valid;

endmodule

// File: tb/tb_thread_context_bank.sv
// Scoreboard bench: two bank instances (default, and 3-slot clear-on-restore) against an array model.
module tb_thread_context_bank;

  localparam int NW = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic        cmd_valid, cmd_op, in_valid, out_ready;
  logic [1:0]  cmd_slot;
  logic [31:0] in_data;

  logic        c0_cmd_valid, c0_in_valid, c1_cmd_valid, c1_in_valid;
  logic        c0_cmd_ready, c0_in_ready, c0_out_valid, c0_err, c0_busy;
  logic        c1_cmd_ready, c1_in_ready, c1_out_valid, c1_err, c1_busy;
  logic [31:0] c0_out_data, c1_out_data;
  logic [3:0]  c0_slot_valid;
  logic [2:0]  c1_slot_valid;

  logic        m_cmd_ready, m_in_ready, m_out_valid, m_err, m_busy;
  logic [31:0] m_out_data;
  logic [3:0]  m_slot_valid;

  assign c0_cmd_valid = cmd_valid && !sel;
  assign c1_cmd_valid = cmd_valid && sel;
  assign c0_in_valid  = in_valid && !sel;
  assign c1_in_valid  = in_valid && sel;
  assign m_cmd_ready  = sel ? c1_cmd_ready : c0_cmd_ready;
  assign m_in_ready   = sel ? c1_in_ready  : c0_in_ready;
  assign m_out_valid  = sel ? c1_out_valid : c0_out_valid;
  assign m_err        = sel ? c1_err       : c0_err;
  assign m_busy       = sel ? c1_busy      : c0_busy;
  assign m_out_data   = sel ? c1_out_data  : c0_out_data;
  assign m_slot_valid = sel ? {1'b0, c1_slot_valid} : c0_slot_valid;

  thread_context_bank #(.DATA_W(32), .NUM_WORDS(NW), .NUM_CTX(4), .CLEAR_ON_RESTORE(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c0_cmd_valid), .cmd_ready(c0_cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .in_valid(c0_in_valid), .in_ready(c0_in_ready),
    .in_data(in_data), .out_valid(c0_out_valid), .out_ready(out_ready), .out_data(c0_out_data),
    .slot_valid(c0_slot_valid), .err(c0_err), .busy(c0_busy)
  );

  thread_context_bank #(.DATA_W(32), .NUM_WORDS(NW), .NUM_CTX(3), .CLEAR_ON_RESTORE(1)) dut_clr (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_data(in_data), .out_valid(c1_out_valid), .out_ready(out_ready), .out_data(c1_out_data),
    .slot_valid(c1_slot_valid), .err(c1_err), .busy(c1_busy)
  );

  // Reference model: per-instance context contents and slot validity.
  logic [31:0] mem [2][4][NW];
  bit          vld [2][4];
  logic [31:0] exp_q[$];
  int          exp_err;
  int          n_checks, n_fail;
  bit          prev_stall;
  logic [31:0] prev_data;

  function automatic int nctx(input bit s);
    return s ? 3 : 4;
  endfunction

  function automatic logic [3:0] exp_sv(input bit s);
    logic [3:0] v;
    v = 4'b0000;
    for (int k = 0; k < nctx(s); k++) v[k] = vld[s][k];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every restore handshake and err pulse against the scoreboard.
  initial begin
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", m_out_valid, 1);
          check("stall_hold_data", m_out_data, prev_data);
        end
        if (m_out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else                   check("out_data", m_out_data, exp_q.pop_front());
        end
        if (m_err) begin
          check("err_expected", exp_err > 0, 1);
          if (exp_err > 0) exp_err--;
        end
        prev_stall = m_out_valid && !out_ready;
        prev_data  = m_out_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) vld[s][k] = 1'b0;
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    check("rst_cmd_ready", m_cmd_ready, 1);
    check("rst_in_ready", m_in_ready, 0);
    check("rst_busy", m_busy, 0);
    check("rst_err", m_err, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_slot_valid", m_slot_valid, 0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input bit op, input logic [1:0] slot, output bit ok);
    cmd_op = op; cmd_slot = slot; cmd_valid = 1'b1; ok = 1'b0;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      if (m_cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("cmd_accept_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic err_seq_check();
    @(negedge clk);
    check("err_pulse", m_err, 1);
    check("err_no_out", m_out_valid, 0);
    check("err_cmd_ready_low", m_cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_one_cycle", m_err, 0);
    check("err_cmd_ready_back", m_cmd_ready, 1);
    check("err_slot_valid", m_slot_valid, exp_sv(sel));
    @(posedge clk); #1;
  endtask

  task automatic save_ctx(input bit s, input logic [1:0] slot, input bit hold,
                          input int nsend, input logic [31:0] base);
    bit ok, got;
    int cycles;
    logic [31:0] w;
    sel = s;
    send_cmd(1'b0, slot, ok);
    if (!ok) return;
    if (int'(slot) >= nctx(s)) begin
      exp_err++;
      err_seq_check();
      return;
    end
    vld[s][slot] = 1'b0;
    cycles = 0;
    for (int i = 0; i < nsend; i++) begin
      w = (base != 32'h0) ? base + 32'(i) : $urandom;
      in_data = w;
      got = 1'b0;
      for (int b = 0; b < 64 && !got; b++) begin
        in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        got = in_valid && m_in_ready;
        cycles++;
        @(posedge clk); #1;
      end
      if (!got) begin
        check("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      mem[s][slot][i] = w;
    end
    in_valid = 1'b0;
    if (nsend == NW) begin
      vld[s][slot] = 1'b1;
      if (hold) check("save_cycles", cycles, NW);
      @(negedge clk);
      check("save_busy_done", m_busy, 0);
      check("save_slot_valid", m_slot_valid, exp_sv(s));
      @(posedge clk); #1;
    end
  endtask

  // mode 0: out_ready held high, 1: toggling, 2: random
  task automatic restore_ctx(input bit s, input logic [1:0] slot, input int mode);
    bit ok;
    int iters;
    sel = s;
    out_ready = (mode == 0) ? 1'b1 : 1'b0;
    send_cmd(1'b1, slot, ok);
    if (!ok) return;
    if (int'(slot) >= nctx(s) || !vld[s][slot]) begin
      exp_err++;
      err_seq_check();
      return;
    end
    for (int i = 0; i < NW; i++) exp_q.push_back(mem[s][slot][i]);
    if (s) vld[s][slot] = 1'b0;
    @(negedge clk);
    check("rd_prime_no_valid", m_out_valid, 0);
    check("rd_prime_busy", m_busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("first_valid_latency", m_out_valid, 1);
    iters = 0;
    for (int b = 0; b < 400; b++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
      iters++;
      if (mode == 1)      out_ready = ~out_ready;
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("restore_drained", exp_q.size(), 0);
    if (mode == 0) check("restore_back_to_back", iters, NW - 1);
    @(negedge clk);
    check("restore_out_valid_done", m_out_valid, 0);
    check("restore_busy_done", m_busy, 0);
    check("restore_slot_valid", m_slot_valid, exp_sv(s));
    @(posedge clk); #1;
  endtask

  initial begin
    bit s, op;
    n_checks = 0; n_fail = 0; exp_err = 0;
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_slot = 2'd0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    do_reset();

    save_ctx(1'b0, 2'd2, 1'b1, NW, 32'hA0);
    check("slot_valid_after_first_save", m_slot_valid, 4'b0100);
    restore_ctx(1'b0, 2'd2, 0);
    restore_ctx(1'b0, 2'd1, 0);
    restore_ctx(1'b0, 2'd2, 1);

    save_ctx(1'b0, 2'd3, 1'b1, 4, 32'h0);
    do_reset();
    restore_ctx(1'b0, 2'd3, 0);

    save_ctx(1'b1, 2'd0, 1'b0, NW, 32'h0);
    restore_ctx(1'b1, 2'd0, 2);
    restore_ctx(1'b1, 2'd0, 0);
    save_ctx(1'b1, 2'd3, 1'b1, NW, 32'h0);

    for (int n = 0; n < 60; n++) begin
      s  = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      if (op) restore_ctx(s, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      else    save_ctx(s, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), NW, 32'h0);
    end

    repeat (3) @(negedge clk);
    check("final_exp_queue_empty", exp_q.size(), 0);
    check("final_err_all_seen", exp_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
